// File: rtl/spi_reg_pkg.sv
// Definitions shared by the SPI register master and slave: register map,
// command-byte layout and the master FSM encoding.
package spi_reg_pkg;

  localparam logic [6:0] FPGA_FW_VERSION = 7'd0;
  localparam logic [6:0] AEROFC_FORCE_BT = 7'd1;

  localparam int   RW_BIT   = 7;
  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SS_SETUP,
    ST_BYTE0,
    ST_GAP,
    ST_BYTE1,
    ST_SS_HOLD,
    ST_DONE
  } spi_state_t;

  // Byte 0 of a transaction: rw flag in the MSB, address below it.
  function automatic logic [7:0] cmd_byte0(input logic write, input logic [6:0] addr);
    logic [7:0] b;
    b         = {1'b0, addr};
    b[RW_BIT] = write ? RW_WRITE : RW_READ;
    return b;
  endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// Mode-0 byte engine: generates 8 SCLK periods per start, shifts MOSI out MSB
// first on falling edges and samples the synchronised MISO on rising edges.
module spi_byte_shifter #(
  parameter int CLK_DIV = 25
) (
  input  logic       clk_core,
  input  logic       reset,
  input  logic       start,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       miso,
  output logic       done,
  output logic       sclk,
  output logic       mosi,
  output logic [7:0] rx_data
);

  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);

  logic [HW-1:0] half_cnt_reg;
  logic [2:0]    bit_cnt_reg;
  logic          active_reg;
  logic          sclk_reg;
  logic [7:0]    tx_shift_reg;
  logic [7:0]    rx_shift_reg;
  logic [1:0]    miso_sync_reg;
  logic          half_end;

  assign half_end = (half_cnt_reg == HALF_LAST);
  // Last cycle of the 8th high phase; the owner advances its FSM on this edge.
  assign done     = active_reg & sclk_reg & half_end & (bit_cnt_reg == 3'd7);
  assign sclk     = sclk_reg;
  assign mosi     = tx_shift_reg[7];
  assign rx_data  = rx_shift_reg;

  always_ff @(posedge clk_core) begin
    if (reset) begin
      half_cnt_reg  <= '0;
      bit_cnt_reg   <= 3'd0;
      active_reg    <= 1'b0;
      sclk_reg      <= 1'b0;
      tx_shift_reg  <= 8'h00;
      rx_shift_reg  <= 8'h00;
      miso_sync_reg <= 2'b00;
    end else begin
      miso_sync_reg <= {miso_sync_reg[0], miso};
      if (start) begin
        active_reg   <= 1'b1;
        half_cnt_reg <= '0;
        bit_cnt_reg  <= 3'd0;
        sclk_reg     <= 1'b0;
      end else if (active_reg) begin
        if (half_end) begin
          half_cnt_reg <= '0;
          sclk_reg     <= ~sclk_reg;
          if (!sclk_reg) begin
            rx_shift_reg <= {rx_shift_reg[6:0], miso_sync_reg[1]};
          end else begin
            tx_shift_reg <= {tx_shift_reg[6:0], 1'b0};
            bit_cnt_reg  <= bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) active_reg <= 1'b0;
          end
        end else begin
          half_cnt_reg <= half_cnt_reg + 1'b1;
        end
      end
      // A load coincides at most with the final falling edge, so it wins.
      if (load) tx_shift_reg <= load_data;
    end
  end

endmodule

// File: rtl/spi_reg_master.sv
// SPI mode-0 master for two-byte register transactions ({rw,addr}, data),
// with a valid/ready command port and a single-cycle response pulse.
module spi_reg_master
  import spi_reg_pkg::*;
#(
  parameter int CLK_DIV    = 25,
  parameter int GAP_CYCLES = 64
) (
  input  logic       clk_core,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       spi_ss
);

  localparam int WAIT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int WW       = $clog2(WAIT_MAX + 1);
  localparam logic [WW-1:0] EDGE_LAST = WW'(CLK_DIV - 1);
  localparam logic [WW-1:0] GAP_LAST  = WW'(GAP_CYCLES - 1);

  spi_state_t    state_reg, state_next;
  logic [WW-1:0] wait_cnt_reg, wait_cnt_next;
  logic [7:0]    byte1_reg;

  logic       ss_reg, ss_next;
  logic       cmd_ready_reg, cmd_ready_next;
  logic       busy_reg, busy_next;
  logic       rsp_valid_reg, rsp_valid_next;
  logic [7:0] rsp_rdata_reg, rsp_rdata_next;

  logic       accept;
  logic       shift_start, shift_load, shift_done;
  logic [7:0] shift_data, shift_rx;

  assign accept      = cmd_valid & (state_reg == ST_IDLE);
  assign shift_start = ((state_reg == ST_SS_SETUP) && (wait_cnt_reg == EDGE_LAST)) ||
                       ((state_reg == ST_GAP) && (wait_cnt_reg == GAP_LAST));
  // Byte 1 is preloaded as byte 0 finishes so MOSI is settled throughout GAP.
  assign shift_load  = accept | ((state_reg == ST_BYTE0) & shift_done);
  assign shift_data  = accept ? cmd_byte0(cmd_write, cmd_addr) : byte1_reg;

  spi_byte_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk_core  (clk_core),
    .reset     (reset),
    .start     (shift_start),
    .load      (shift_load),
    .load_data (shift_data),
    .miso      (spi_miso),
    .done      (shift_done),
    .sclk      (spi_sclk),
    .mosi      (spi_mosi),
    .rx_data   (shift_rx)
  );

  always_ff @(posedge clk_core) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      wait_cnt_reg  <= '0;
      byte1_reg     <= 8'h00;
      ss_reg        <= 1'b1;
      cmd_ready_reg <= 1'b1;
      busy_reg      <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= 8'h00;
    end else begin
      state_reg     <= state_next;
      wait_cnt_reg  <= wait_cnt_next;
      if (accept) byte1_reg <= (cmd_write == RW_READ) ? 8'h00 : cmd_wdata;
      ss_reg        <= ss_next;
      cmd_ready_reg <= cmd_ready_next;
      busy_reg      <= busy_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_rdata_reg <= rsp_rdata_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:     if (accept)                     state_next = ST_SS_SETUP;
      ST_SS_SETUP: if (wait_cnt_reg == EDGE_LAST)  state_next = ST_BYTE0;
      ST_BYTE0:    if (shift_done)                 state_next = ST_GAP;
      ST_GAP:      if (wait_cnt_reg == GAP_LAST)   state_next = ST_BYTE1;
      ST_BYTE1:    if (shift_done)                 state_next = ST_SS_HOLD;
      ST_SS_HOLD:  if (wait_cnt_reg == EDGE_LAST)  state_next = ST_DONE;
      ST_DONE:                                     state_next = ST_IDLE;
      default:                                     state_next = ST_IDLE;
    endcase
    wait_cnt_next = '0;
    if ((state_next == state_reg) &&
        (state_reg == ST_SS_SETUP || state_reg == ST_GAP || state_reg == ST_SS_HOLD))
      wait_cnt_next = wait_cnt_reg + 1'b1;
  end

  // Outputs are registered from the next state so they align with it exactly.
  always_comb begin
    ss_next        = (state_next == ST_IDLE) || (state_next == ST_DONE);
    cmd_ready_next = (state_next == ST_IDLE);
    busy_next      = (state_next != ST_IDLE);
    rsp_valid_next = (state_next == ST_DONE);
    rsp_rdata_next = rsp_valid_next ? shift_rx : rsp_rdata_reg;
  end

  assign spi_ss    = ss_reg;
  assign cmd_ready = cmd_ready_reg;
  assign busy      = busy_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;

endmodule

// File: tb/tb_spi_reg_master.sv
// Bench for spi_reg_master: two instances (default timing and CLK_DIV=2/GAP=1)
// each talking to a behavioural SPI register slave kept in the bench.
module tb_spi_reg_master;
  import spi_reg_pkg::*;

  localparam int CD0 = 25, G0 = 64;
  localparam int CD1 = 2,  G1 = 1;

  logic       clk_core = 1'b0;
  logic [1:0] reset, cmd_valid, cmd_ready, cmd_write, rsp_valid, busy;
  logic [1:0] spi_sclk, spi_mosi, spi_ss;
  logic [1:0] spi_miso = 2'b00;
  logic [6:0] cmd_addr  [2];
  logic [7:0] cmd_wdata [2];
  logic [7:0] rsp_rdata [2];

  always #5 clk_core = ~clk_core;

  spi_reg_master #(.CLK_DIV(CD0), .GAP_CYCLES(G0)) u_dut0 (
    .clk_core(clk_core), .reset(reset[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_write(cmd_write[0]), .cmd_addr(cmd_addr[0]), .cmd_wdata(cmd_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .busy(busy[0]),
    .spi_sclk(spi_sclk[0]), .spi_mosi(spi_mosi[0]), .spi_miso(spi_miso[0]), .spi_ss(spi_ss[0]));

  spi_reg_master #(.CLK_DIV(CD1), .GAP_CYCLES(G1)) u_dut1 (
    .clk_core(clk_core), .reset(reset[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_write(cmd_write[1]), .cmd_addr(cmd_addr[1]), .cmd_wdata(cmd_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .busy(busy[1]),
    .spi_sclk(spi_sclk[1]), .spi_mosi(spi_mosi[1]), .spi_miso(spi_miso[1]), .spi_ss(spi_ss[1]));

  int n_vec = 0;
  int n_err = 0;

  // Slave model state, one set per instance.
  logic [7:0]  regs [2][128];
  logic [15:0] mosi_bits [2];
  logic [7:0]  tx_byte [2];
  logic [7:0]  last_b0 [2], last_b1 [2];
  int          rises [2], ss_low [2], rsp_cnt [2], txn_cnt [2], bad_mode [2];
  int          last_low [2], last_rises [2];
  logic [1:0]  prev_ss = 2'b11, prev_sclk = 2'b00, prev_mosi = 2'b00;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ss_len(input int k);
    return (k == 0) ? 34 * CD0 + G0 : 34 * CD1 + G1;
  endfunction

  // Mode-0 slave: samples MOSI on SCLK rise, drives MISO after each fall,
  // returns regs[addr] in byte 1 and commits writes when SS releases.
  always @(negedge clk_core) begin
    for (int k = 0; k < 2; k++) begin
      if (reset[k]) begin
        rises[k] = 0; ss_low[k] = 0; mosi_bits[k] = 16'h0;
      end else begin
        if (rsp_valid[k]) rsp_cnt[k]++;
        if (spi_ss[k] && spi_sclk[k]) bad_mode[k]++;
        if (!spi_ss[k]) begin
          ss_low[k]++;
          if (!prev_ss[k]) begin
            if (spi_sclk[k] && !prev_sclk[k]) begin
              if (spi_mosi[k] != prev_mosi[k]) bad_mode[k]++;
              mosi_bits[k] = {mosi_bits[k][14:0], spi_mosi[k]};
              rises[k]++;
              if (rises[k] == 8) tx_byte[k] = regs[k][mosi_bits[k][6:0]];
            end else if (!spi_sclk[k] && prev_sclk[k]) begin
              if (rises[k] >= 8 && rises[k] < 16) spi_miso[k] = tx_byte[k][3'(15 - rises[k])];
              else spi_miso[k] = 1'($urandom_range(1));
            end else if (spi_mosi[k] != prev_mosi[k]) begin
              bad_mode[k]++;
            end
          end
        end else if (!prev_ss[k]) begin
          last_b0[k] = mosi_bits[k][15:8];
          last_b1[k] = mosi_bits[k][7:0];
          last_low[k] = ss_low[k];
          last_rises[k] = rises[k];
          txn_cnt[k]++;
          if (rises[k] == 16 && mosi_bits[k][15]) regs[k][mosi_bits[k][14:8]] = mosi_bits[k][7:0];
          rises[k] = 0; ss_low[k] = 0; mosi_bits[k] = 16'h0;
        end
      end
      prev_ss[k] = spi_ss[k]; prev_sclk[k] = spi_sclk[k]; prev_mosi[k] = spi_mosi[k];
    end
  end

  task automatic issue(input int k, input logic w, input logic [6:0] a, input logic [7:0] d);
    cmd_valid[k] = 1'b1; cmd_write[k] = w; cmd_addr[k] = a; cmd_wdata[k] = d;
  endtask

  // Called at a negedge; returns after the accept edge, at the following negedge.
  task automatic wait_accept(input int k, output logic [7:0] exp_rd, output int waited);
    waited = 0;
    exp_rd = 8'h00;
    while (!cmd_ready[k] && waited < 5000) begin
      @(negedge clk_core);
      waited++;
    end
    if (!cmd_ready[k]) begin
      check_eq("accept_timeout", 32'd0, 32'd1);
      return;
    end
    exp_rd = regs[k][cmd_addr[k]];
    @(posedge clk_core);
    @(negedge clk_core);
    check_eq("ss_fall", spi_ss[k], 1'b0);
    check_eq("busy_accept", busy[k], 1'b1);
    check_eq("ready_accept", cmd_ready[k], 1'b0);
  endtask

  task automatic finish_txn(input int k, input logic w, input logic [6:0] a, input logic [7:0] d,
                            input logic [7:0] exp_rd, input bit chk_data);
    int cyc = 0, ready_hi = 0;
    int rsp0 = rsp_cnt[k], txn0 = txn_cnt[k];
    do begin
      @(negedge clk_core);
      cyc++;
      if (!rsp_valid[k] && cmd_ready[k]) ready_hi++;
    end while (!rsp_valid[k] && cyc < 5000);
    check_eq("rsp_seen", rsp_valid[k], 1'b1);
    check_eq("rsp_latency", cyc, ss_len(k));
    check_eq("ready_low_busy", ready_hi, 0);
    check_eq("ss_high_at_rsp", spi_ss[k], 1'b1);
    check_eq("busy_at_rsp", busy[k], 1'b1);
    if (chk_data) check_eq("rsp_rdata", rsp_rdata[k], exp_rd);
    @(negedge clk_core);
    check_eq("rsp_pulse_end", rsp_valid[k], 1'b0);
    check_eq("ready_after", cmd_ready[k], 1'b1);
    check_eq("busy_after", busy[k], 1'b0);
    check_eq("ss_idle", spi_ss[k], 1'b1);
    check_eq("rsp_count", rsp_cnt[k] - rsp0, 1);
    check_eq("frame_count", txn_cnt[k] - txn0, 1);
    check_eq("mosi_byte0", last_b0[k], cmd_byte0(w, a));
    check_eq("mosi_byte1", last_b1[k], w ? d : 8'h00);
    check_eq("ss_low_len", last_low[k], ss_len(k));
    check_eq("sclk_rises", last_rises[k], 16);
    check_eq("mode0_violations", bad_mode[k], 0);
    $display("txn dut%0d %s addr=0x%02h wdata=0x%02h rdata=0x%02h exp=0x%02h ss_low=%0d",
             k, w ? "WR" : "RD", a, d, rsp_rdata[k], exp_rd, last_low[k]);
  endtask

  task automatic run_cmd(input int k, input logic w, input logic [6:0] a, input logic [7:0] d,
                         input bit chk_data);
    logic [7:0] exp_rd;
    int waited;
    issue(k, w, a, d);
    wait_accept(k, exp_rd, waited);
    cmd_valid[k] = 1'b0;
    finish_txn(k, w, a, d, exp_rd, chk_data);
  endtask

  initial begin
    logic [7:0] e1, e2;
    int w1, w2, guard, rsp0;
    reset = 2'b11; cmd_valid = 2'b00; cmd_write = 2'b00;
    for (int k = 0; k < 2; k++) begin
      cmd_addr[k] = 7'h0; cmd_wdata[k] = 8'h0;
      rises[k] = 0; ss_low[k] = 0; rsp_cnt[k] = 0; txn_cnt[k] = 0; bad_mode[k] = 0;
      mosi_bits[k] = 16'h0; tx_byte[k] = 8'h0; last_b0[k] = 8'h0; last_b1[k] = 8'h0;
      last_low[k] = 0; last_rises[k] = 0;
      for (int i = 0; i < 128; i++) regs[k][i] = 8'(i * 37 + 17);
      regs[k][FPGA_FW_VERSION] = 8'hC2;
      regs[k][AEROFC_FORCE_BT] = 8'h00;
    end
    repeat (3) @(negedge clk_core);
    for (int k = 0; k < 2; k++) begin
      check_eq("rst_ss", spi_ss[k], 1'b1);
      check_eq("rst_sclk", spi_sclk[k], 1'b0);
      check_eq("rst_mosi", spi_mosi[k], 1'b0);
      check_eq("rst_ready", cmd_ready[k], 1'b1);
      check_eq("rst_busy", busy[k], 1'b0);
      check_eq("rst_rsp_valid", rsp_valid[k], 1'b0);
      check_eq("rst_rdata", rsp_rdata[k], 8'h00);
    end
    reset = 2'b00;
    repeat (2) @(negedge clk_core);

    // Firmware-version read, then write/read-back of the force register.
    run_cmd(0, RW_READ, FPGA_FW_VERSION, 8'h5A, 1);
    check_eq("fw_version", rsp_rdata[0], 8'hC2);
    run_cmd(0, RW_WRITE, AEROFC_FORCE_BT, 8'h01, 1);
    check_eq("force_bt_reg", regs[0][AEROFC_FORCE_BT], 8'h01);
    run_cmd(0, RW_READ, AEROFC_FORCE_BT, 8'h00, 1);
    check_eq("force_bt_read", rsp_rdata[0], 8'h01);

    // cmd_valid held high across two commands: second accepted right after DONE.
    issue(0, RW_WRITE, 7'h22, 8'hA5);
    wait_accept(0, e1, w1);
    issue(0, RW_READ, 7'h22, 8'h00);
    finish_txn(0, RW_WRITE, 7'h22, 8'hA5, e1, 1);
    wait_accept(0, e2, w2);
    check_eq("b2b_wait", w2, 0);
    cmd_valid[0] = 1'b0;
    finish_txn(0, RW_READ, 7'h22, 8'h00, e2, 1);
    check_eq("b2b_readback", rsp_rdata[0], 8'hA5);

    // Reset in the middle of byte 0.
    issue(0, RW_READ, 7'h05, 8'h00);
    wait_accept(0, e1, w1);
    cmd_valid[0] = 1'b0;
    guard = 0;
    while (rises[0] < 3 && guard < 2000) begin
      @(negedge clk_core);
      guard++;
    end
    check_eq("abort_reached_bit3", rises[0], 3);
    rsp0 = rsp_cnt[0];
    reset[0] = 1'b1;
    @(negedge clk_core);
    check_eq("abort_ss", spi_ss[0], 1'b1);
    check_eq("abort_sclk", spi_sclk[0], 1'b0);
    check_eq("abort_rsp_valid", rsp_valid[0], 1'b0);
    check_eq("abort_ready", cmd_ready[0], 1'b1);
    reset[0] = 1'b0;
    repeat (60) @(negedge clk_core);
    check_eq("abort_no_rsp", rsp_cnt[0] - rsp0, 0);
    run_cmd(0, RW_READ, FPGA_FW_VERSION, 8'h00, 1);
    check_eq("post_abort_fw", rsp_rdata[0], 8'hC2);

    for (int i = 0; i < 8; i++)
      run_cmd(0, 1'($urandom_range(1)), 7'($urandom_range(127)), 8'($urandom_range(255)), 1);

    // Fast instance: framing and timing only.
    for (int i = 0; i < 60; i++)
      run_cmd(1, 1'($urandom_range(1)), 7'($urandom_range(127)), 8'($urandom_range(255)), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_reg_master.md
Name: spi_reg_master

Overview:
- SPI mode-0 master that issues the two-byte register transactions our SPI register slave decodes.
- Byte 0 is {rw, addr[6:0]}, where rw=1 means write and rw=0 means read. Byte 1 is write data on MOSI, or read data returned on MISO.
- Used on the FPGA to drive an external SPI register device, and as the bench/loopback initiator for our own slave.
- Presents a valid/ready command port and a single-pulse response port to the core logic.

Parameters:
- CLK_DIV, 25: SCLK half-period in clk_core cycles. Must be ≥ 2. Gives 1 MHz SCLK at 50 MHz.
- GAP_CYCLES, 64: idle cycles between byte 0 and byte 1, with SCLK low and SS held low. Gives the slave time to load its tx byte. Must be ≥ 1.

Ports:
- clk_core, in, 1: system clock (50 MHz).
- reset, in, 1: synchronous, active-high reset.
- cmd_valid, in, 1: command request.
- cmd_ready, out, 1: high only in IDLE.
- cmd_write, in, 1: 1 = write, 0 = read.
- cmd_addr, in, 7: register address.
- cmd_wdata, in, 8: write data. Ignored for reads; byte 1 MOSI is sent as 0x00.
- rsp_valid, out, 1: one-cycle pulse at transaction end.
- rsp_rdata, out, 8: byte captured from MISO during byte 1. Held until the next rsp_valid.
- busy, out, 1: high from command accept until the rsp_valid cycle, inclusive.
- spi_sclk, out, 1: SPI clock, CPOL=0.
- spi_mosi, out, 1: master out.
- spi_miso, in, 1: master in. Double-flop synchronised before sampling.
- spi_ss, out, 1: slave select, active low.

Behaviour:
- Reset values: spi_ss=1, spi_sclk=0, spi_mosi=0, cmd_ready=1, busy=0, rsp_valid=0, rsp_rdata=0x00, state=IDLE. All outputs are registered.
- Handshake: a command is accepted on the edge where cmd_valid & cmd_ready. All cmd_* inputs are latched on that edge. cmd_valid while busy is ignored and never queued.
- Byte framing: MSB first, mode 0.
  - MOSI is valid before each rising edge and changes only on falling edges.
  - Bit 7 is driven during SS_SETUP.
  - Each bit is SCLK low for CLK_DIV cycles, then high for CLK_DIV cycles. One byte takes 16*CLK_DIV cycles.
  - The MISO sample (synchronised value) is taken in the cycle SCLK is driven high.
- States:
  - IDLE: spi_ss=1. On accept, go to SS_SETUP.
  - SS_SETUP: spi_ss=0 for CLK_DIV cycles, MOSI = byte0[7]. Then go to BYTE0.
  - BYTE0: shift 8 bits of {cmd_write, cmd_addr}. After the 8th high phase completes, SCLK returns low; go to GAP.
  - GAP: GAP_CYCLES cycles, SCLK low. MOSI = byte1[7] by the last cycle. Then go to BYTE1.
  - BYTE1: shift cmd_wdata (or 0x00 for reads) while capturing MISO. Then go to SS_HOLD.
  - SS_HOLD: SCLK low, spi_ss=0 for CLK_DIV cycles. Then go to DONE.
  - DONE: spi_ss=1, rsp_valid=1, rsp_rdata=captured byte. Next cycle go to IDLE (cmd_ready=1).
- Timing: spi_ss is low for exactly 34*CLK_DIV + GAP_CYCLES cycles. It falls one cycle after accept. rsp_valid rises in the cycle spi_ss returns high. Exactly 16 SCLK rising edges occur per transaction.
- Writes: rsp_rdata is still updated with whatever MISO returned during byte 1.
- Back-to-back commands: the earliest next accept is the cycle after DONE, so spi_ss is high for at least 1 cycle between transactions.
- Reset mid-transaction: on the next edge spi_ss=1, spi_sclk=0, rsp_valid=0 and the FSM is in IDLE. No response is emitted for the aborted command.
- Counters: half-period counter width is clog2(CLK_DIV). Gap counter width is clog2(GAP_CYCLES+1). Bit counter is 3 bits and wraps 7→0 at a byte end.

Decomposition:
- Shared package spi_reg_pkg contains:
  - register address constants: FPGA_FW_VERSION=7'd0, AEROFC_FORCE_BT=7'd1;
  - RW bit index 7, with WRITE=1 and READ=0;
  - FSM state encoding.
  The slave-side decoder also uses this package.
- Sub-module spi_byte_shifter:
  - owns the SCLK half-period counter, 3-bit bit counter, MOSI shift register and MISO capture;
  - start/done handshake, one byte per start.
  The top FSM sequences SS_SETUP/GAP/SS_HOLD around two shifter runs.

Test Plan:
- Read: cmd_write=0, cmd_addr=0x00. Slave model returns 0xC2 on byte 1. Expect MOSI bytes 0x00,0x00; rsp_valid pulses once with rsp_rdata=0xC2; spi_ss low exactly 34*25+64 = 914 cycles.
- Write: cmd_write=1, cmd_addr=0x01, cmd_wdata=0x01. Expect MOSI bytes 0x81,0x01; the slave model's AEROFC_FORCE_BT register = 1. Follow with a read of 0x01 and expect rsp_rdata=0x01.
- Mode/timing checks with CLK_DIV=2, GAP_CYCLES=1:
  - MOSI stable across every rising SCLK edge;
  - SCLK idles low;
  - 16 rising edges per transaction;
  - spi_ss low exactly 69 cycles.
- Busy handling: hold cmd_valid high continuously with two different commands. Expect the second to be accepted only the cycle after rsp_valid, cmd_ready=0 throughout busy, and spi_ss high ≥ 1 cycle between transactions.
- Reset mid-transaction: assert reset during BYTE0 bit 3. Expect spi_ss=1, spi_sclk=0, no rsp_valid, cmd_ready=1 on the next edge. A subsequent read of 0x00 still returns 0xC2.
